// File: rtl/riscv_loader_pkg.sv
// Shared constants for the Wishbone IMEM loader: register word offsets,
// CTRL/STATUS bit positions and the bus-side FSM encoding.
package riscv_loader_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PTR    = 2'd1;
    localparam logic [1:0] OFF_DATA   = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int unsigned CTRL_RUN     = 0;
    localparam int unsigned CTRL_PTR_CLR = 1;

    localparam int unsigned STAT_RUNNING  = 0;
    localparam int unsigned STAT_FULL     = 1;
    localparam int unsigned STAT_ERR      = 2;
    localparam int unsigned STAT_CNT_LSB  = 16;
    localparam int unsigned STAT_READBACK = 31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } state_t;

endpackage

// File: rtl/riscv_wb_loader.sv
// Wishbone slave that loads instruction words into a RISC-V core IMEM and
// holds the core in reset until run is set. Optional IMEM readback: RISCV_LOADER_READBACK_EN.
module riscv_wb_loader
    import riscv_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned IMEM_DEPTH = 64,
    localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          imem_we_o,
    output logic [AW-1:0] imem_addr_o,
    output logic [31:0]   imem_wdata_o,
    input  logic [31:0]   imem_rdata_i,
    output logic          core_halt_o
);

    state_t        state, state_next;
    logic          ack, ack_d;
    logic [31:0]   rdata, rdata_d;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          run, halt, full, err;
    logic [AW-1:0] ptr;
    logic [7:0]    count;
    logic          hit;
    logic [1:0]    off;
    logic [31:0]   status;
    logic          do_ctrl, do_ptr, do_load, do_reject;
    logic          unused;

    assign unused = ^{1'b0, wbs_sel_i, wbs_adr_i[1:0], imem_rdata_i};

    assign hit = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign off = wbs_adr_i[3:2];

    always_comb begin
        status                         = '0;
        status[STAT_RUNNING]           = run;
        status[STAT_FULL]              = full;
        status[STAT_ERR]               = err;
        status[STAT_CNT_LSB +: 8]      = count;
`ifdef RISCV_LOADER_READBACK_EN
        status[STAT_READBACK]          = 1'b1;
`endif
    end

    always_comb begin
        state_next = state;
        ack_d      = 1'b0;
        rdata_d    = '0;
        do_ctrl    = 1'b0;
        do_ptr     = 1'b0;
        do_load    = 1'b0;
        do_reject  = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_next = ACK;
                    ack_d      = 1'b1;
                    if (wbs_we_i) begin
                        case (off)
                            OFF_CTRL: do_ctrl   = 1'b1;
                            OFF_PTR:  do_ptr    = 1'b1;
                            OFF_DATA: begin
                                do_load   = !run;
                                do_reject = run;
                            end
                            default: ;
                        endcase
                    end else begin
                        case (off)
                            OFF_CTRL:   rdata_d[CTRL_RUN] = run;
                            OFF_PTR:    rdata_d           = 32'(ptr);
                            OFF_STATUS: rdata_d           = status;
`ifdef RISCV_LOADER_READBACK_EN
                            OFF_DATA: begin
                                state_next = RD_WAIT;
                                ack_d      = 1'b0;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            RD_WAIT: begin
                // Master abandoning the cycle here must not see a late ack.
                if (wbs_stb_i && wbs_cyc_i) begin
                    state_next = ACK;
                    ack_d      = 1'b1;
                    rdata_d    = imem_rdata_i;
                end else begin
                    state_next = IDLE;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // IMEM address trails PTR by one cycle, so the write pulse carries the pre-increment index.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            ack       <= 1'b0;
            rdata     <= '0;
            load_we   <= 1'b0;
            load_addr <= '0;
            load_data <= '0;
            run       <= 1'b0;
            halt      <= 1'b1;
            ptr       <= '0;
            count     <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            ack       <= ack_d;
            rdata     <= rdata_d;
            load_we   <= do_load;
            load_addr <= ptr;
            if (do_load) begin
                load_data <= wbs_dat_i;
                ptr       <= ptr + 1'b1;
                if (ptr == '1)
                    full <= 1'b1;
                if (count != '1)
                    count <= count + 8'd1;
            end
            if (do_reject)
                err <= 1'b1;
            if (do_ptr)
                ptr <= wbs_dat_i[AW-1:0];
            if (do_ctrl) begin
                run  <= wbs_dat_i[CTRL_RUN];
                halt <= ~wbs_dat_i[CTRL_RUN];
                if (wbs_dat_i[CTRL_PTR_CLR]) begin
                    ptr   <= '0;
                    count <= '0;
                    full  <= 1'b0;
                end
            end
        end
    end

    assign wbs_ack_o    = ack;
    assign wbs_dat_o    = rdata;
    assign imem_we_o    = load_we;
    assign imem_addr_o  = load_addr;
    assign imem_wdata_o = load_data;
    assign core_halt_o  = halt;

endmodule

// File: tb/tb_riscv_wb_loader.sv
// Self-checking bench for riscv_wb_loader: register-access vector table,
// IMEM write scoreboard, and hand sequences for wrap, saturation, decode and reset.
module tb_riscv_wb_loader;
    import riscv_loader_pkg::*;

    localparam logic [31:0] BASE_ADDR = 32'h3000_0000;
`ifdef RISCV_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam logic [31:0] RB_BIT = RB ? 32'h8000_0000 : 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata = '0;
    logic        halt;

    riscv_wb_loader #(.BASE_ADDR(BASE_ADDR), .IMEM_DEPTH(64)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .imem_we_o   (imem_we),
        .imem_addr_o (imem_addr),
        .imem_wdata_o(imem_wdata),
        .imem_rdata_i(imem_rdata),
        .core_halt_o (halt)
    );

    always #5 clk = ~clk;

    // Registered-read IMEM stand-in
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
        imem_rdata <= mem[imem_addr];
    end

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        we;
        logic [1:0]  off;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic        load;
        logic [5:0]  waddr;
        logic        exp_halt;
    } vec_t;

    wr_t  sb[$];
    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   wr_seen = 0;
    logic prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one cycle and check any IMEM write pulse against the scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (imem_we === 1'b1) begin
            wr_seen++;
            check("we_one_cycle", {31'b0, prev_we}, 32'h0);
            if (sb.size() == 0) begin
                check("we_unexpected", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                check("imem_addr", 32'(imem_addr), 32'(e.addr));
                check("imem_wdata", imem_wdata, e.data);
            end
        end
        prev_we = imem_we;
    endtask

    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] rd, output int lat, output logic h);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
        lat = -1; rd = '0; h = 1'bx;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (ack === 1'b1) begin
                lat = n; rd = rdat; h = halt;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        tick();
        check("ack_dropped", {31'b0, ack}, 32'h0);
        check("dat_idle_zero", rdat, 32'h0);
    endtask

    task automatic add(input logic w, input logic [1:0] o, input logic [31:0] d,
                       input logic [31:0] er, input int el, input logic ld,
                       input logic [5:0] wa, input logic eh);
        vec_t v;
        v.we = w; v.off = o; v.wd = d; v.exp_rd = er; v.exp_lat = el;
        v.load = ld; v.waddr = wa; v.exp_halt = eh;
        vq.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        h;
        int          seen0;
        int          acks;
        vec_t        v;

        // Reset values
        tick(); tick();
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_we", {31'b0, imem_we}, 32'h0);
        check("rst_addr", 32'(imem_addr), 32'h0);
        check("rst_halt", {31'b0, halt}, 32'h1);
        rst = 1'b0;

        add(0, OFF_STATUS, 0,     RB_BIT,               1, 0, 0,  1);
        add(0, OFF_CTRL,   0,     32'h0,                1, 0, 0,  1);
        add(0, OFF_PTR,    0,     32'h0,                1, 0, 0,  1);
        add(1, OFF_DATA,   32'h13, 0,                   1, 1, 0,  1);
        add(1, OFF_DATA,   32'h13, 0,                   1, 1, 1,  1);
        add(1, OFF_DATA,   32'h13, 0,                   1, 1, 2,  1);
        add(0, OFF_STATUS, 0,     RB_BIT | 32'h0003_0000, 1, 0, 0, 1);
        add(0, OFF_PTR,    0,     32'h3,                1, 0, 0,  1);
        add(1, OFF_PTR,    32'hFFFF_FFFF, 0,            1, 0, 0,  1);
        add(0, OFF_PTR,    0,     32'h3F,               1, 0, 0,  1);
        add(1, OFF_DATA,   32'hA5, 0,                   1, 1, 63, 1);
        add(1, OFF_DATA,   32'h5A, 0,                   1, 1, 0,  1);
        add(0, OFF_STATUS, 0,     RB_BIT | 32'h0005_0002, 1, 0, 0, 1);
        add(0, OFF_PTR,    0,     32'h1,                1, 0, 0,  1);
        add(1, OFF_CTRL,   32'h1, 0,                    1, 0, 0,  0);
        add(0, OFF_STATUS, 0,     RB_BIT | 32'h0005_0003, 1, 0, 0, 0);
        add(1, OFF_DATA,   32'h77, 0,                   1, 0, 0,  0);
        add(0, OFF_STATUS, 0,     RB_BIT | 32'h0005_0007, 1, 0, 0, 0);
        add(0, OFF_PTR,    0,     32'h1,                1, 0, 0,  0);
        add(1, OFF_CTRL,   32'h2, 0,                    1, 0, 0,  1);
        add(0, OFF_STATUS, 0,     RB_BIT | 32'h0000_0004, 1, 0, 0, 1);
        add(0, OFF_PTR,    0,     32'h0,                1, 0, 0,  1);
        add(0, OFF_CTRL,   0,     32'h0,                1, 0, 0,  1);
        add(0, OFF_DATA,   0,     RB ? 32'h5A : 32'h0,  RB ? 2 : 1, 0, 0, 1);
        add(1, OFF_CTRL,   32'h3, 0,                    1, 0, 0,  0);
        add(0, OFF_CTRL,   0,     32'h1,                1, 0, 0,  0);
        add(1, OFF_CTRL,   32'h0, 0,                    1, 0, 0,  1);

        foreach (vq[i]) begin
            v = vq[i];
            seen0 = wr_seen;
            if (v.load) sb.push_back('{v.waddr, v.wd});
            wb_xfer(BASE_ADDR + {28'd0, v.off, 2'b00}, v.we, v.wd, rd, lat, h);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(v.exp_lat));
            if (!v.we) check($sformatf("v%0d_rdata", i), rd, v.exp_rd);
            check($sformatf("v%0d_halt_at_ack", i), {31'b0, h}, {31'b0, v.exp_halt});
            if (v.we && v.off == OFF_DATA)
                check($sformatf("v%0d_we_pulses", i), 32'(wr_seen - seen0), {31'b0, v.load});
        end

        // Count saturates at 255 while PTR keeps wrapping
        for (int i = 0; i < 260; i++) begin
            sb.push_back('{6'(i), 32'h1000_0000 + 32'(i)});
            wb_xfer(BASE_ADDR + 32'h8, 1'b1, 32'h1000_0000 + 32'(i), rd, lat, h);
        end
        wb_xfer(BASE_ADDR + 32'hC, 1'b0, 0, rd, lat, h);
        check("sat_status", rd, RB_BIT | 32'h00FF_0006);
        wb_xfer(BASE_ADDR + 32'h4, 1'b0, 0, rd, lat, h);
        check("sat_ptr", rd, 32'd4);

        // Addresses outside the window: no ack, no side effects
        acks = 0;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; wdat = 32'h1;
        adr = BASE_ADDR + 32'h18;
        for (int n = 0; n < 4; n++) begin tick(); if (ack) acks++; end
        adr = BASE_ADDR - 32'h4;
        for (int n = 0; n < 4; n++) begin tick(); if (ack) acks++; end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        tick();
        check("miss_no_ack", 32'(acks), 32'h0);
        wb_xfer(BASE_ADDR, 1'b0, 0, rd, lat, h);
        check("miss_ctrl", rd, 32'h0);
        check("miss_halt", {31'b0, halt}, 32'h1);

`ifdef RISCV_LOADER_READBACK_EN
        wb_xfer(BASE_ADDR + 32'h4, 1'b1, 32'h2, rd, lat, h);
        sb.push_back('{6'd2, 32'hDEAD_BEEF});
        wb_xfer(BASE_ADDR + 32'h8, 1'b1, 32'hDEAD_BEEF, rd, lat, h);
        wb_xfer(BASE_ADDR + 32'h4, 1'b1, 32'h2, rd, lat, h);
        wb_xfer(BASE_ADDR + 32'h8, 1'b0, 0, rd, lat, h);
        check("rb_lat", 32'(lat), 32'd2);
        check("rb_data", rd, 32'hDEAD_BEEF);
        wb_xfer(BASE_ADDR + 32'h4, 1'b0, 0, rd, lat, h);
        check("rb_ptr", rd, 32'h2);

        // Master drops the cycle while the read is pending
        acks = 0;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE_ADDR + 32'h8;
        tick();
        if (ack) acks++;
        stb = 1'b0; cyc = 1'b0;
        for (int n = 0; n < 3; n++) begin tick(); if (ack) acks++; end
        check("abort_no_ack", 32'(acks), 32'h0);
        wb_xfer(BASE_ADDR, 1'b0, 0, rd, lat, h);
        check("abort_next_lat", 32'(lat), 32'd1);
`endif

        // Reset mid-transaction
        wb_xfer(BASE_ADDR, 1'b1, 32'h1, rd, lat, h);
        check("pre_rst_halt", {31'b0, halt}, 32'h0);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE_ADDR + 32'h8;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_ack", {31'b0, ack}, 32'h0);
        check("mid_rst_dat", rdat, 32'h0);
        check("mid_rst_halt", {31'b0, halt}, 32'h1);
        stb = 1'b0; cyc = 1'b0;
        tick(); tick();
        check("in_rst_ack", {31'b0, ack}, 32'h0);
        rst = 1'b0;
        tick();
        wb_xfer(BASE_ADDR + 32'hC, 1'b0, 0, rd, lat, h);
        check("post_rst_status", rd, RB_BIT);
        check("post_rst_lat", 32'(lat), 32'd1);
        wb_xfer(BASE_ADDR + 32'h4, 1'b0, 0, rd, lat, h);
        check("post_rst_ptr", rd, 32'h0);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
